bp_me_cce_mem_cmd_arbiter: RTL and testbench
============================================

Name: bp_me_cce_mem_cmd_arbiter

Overview:
- Shares one CCE memory command/response channel pair among num_req_p independent cache-DMA-to-CCE converters, each instantiated 1:1.
- Commands are arbitrated round-robin onto the downstream mem_cmd channel.
- The requester index of every issued command is recorded in an in-order tag FIFO.
- Each mem_resp is steered back to the requester at the FIFO head.
- Sits between the per-cache DMA converters and the memory-side CCE/mem interface.

Parameters:
- num_req_p, 2, number of requesters (1..16).
- mem_msg_width_p, cce_mem_msg_width_lp, width of one packed bp_cce_mem_msg_s.
- tag_fifo_els_p, 8, maximum outstanding commands (power of 2, at least 2).
- lg_num_req_lp, `BSG_SAFE_CLOG2(num_req_p), localparam, requester index width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- mem_cmd_i  in  num_req_p*mem_msg_width_p  per-requester command.
- mem_cmd_v_i  in  num_req_p  per-requester command valid.
- mem_cmd_yumi_o  out  num_req_p  per-requester command consumed.
- mem_cmd_o  out  mem_msg_width_p  arbitrated command.
- mem_cmd_v_o  out  1  arbitrated command valid.
- mem_cmd_yumi_i  in  1  downstream consumed command.
- mem_resp_i  in  mem_msg_width_p  response from memory.
- mem_resp_v_i  in  1  response valid.
- mem_resp_ready_o  out  1  arbiter can accept response.
- mem_resp_o  out  mem_msg_width_p  response, broadcast to all requesters.
- mem_resp_v_o  out  num_req_p  one-hot response valid.
- mem_resp_ready_i  in  num_req_p  per-requester response ready.
- outstanding_o  out  `BSG_WIDTH(tag_fifo_els_p)  commands issued but not yet answered.

Behaviour:
- Reset values:
  - State is IDLE; round-robin pointer is 0 (requester 0 has highest priority first); tag FIFO is empty; outstanding_o = 0.
  - All valid and yumi outputs are 0; mem_resp_ready_o = 0.
- Command state machine, IDLE/HOLD:
  - IDLE: if any mem_cmd_v_i is set and the tag FIFO is not full, grant the first valid requester at or after the RR pointer (wrapping), combinationally in the same cycle.
  - IDLE, granted: mem_cmd_v_o = 1 and mem_cmd_o = mem_cmd_i[grant].
    - If mem_cmd_yumi_i is 1 the same cycle: assert mem_cmd_yumi_o[grant], push grant into the tag FIFO, set the RR pointer to grant+1 mod num_req_p, and stay in IDLE.
    - Otherwise: latch grant into grant_r and go to HOLD.
  - HOLD: mem_cmd_v_o = 1 and mem_cmd_o = mem_cmd_i[grant_r]. No re-arbitration, so mem_cmd_o stays stable under the valid-then-yumi contract. On mem_cmd_yumi_i: yumi grant_r, push to the FIFO, advance the pointer, return to IDLE.
  - Requesters must hold valid and data until yumi. The downstream side must not raise yumi without valid.
  - Tag FIFO full: mem_cmd_v_o = 0 in IDLE; no grant is made and the pointer does not move.
  - HOLD is entered only with a free FIFO slot. Responses only free slots, so the push in HOLD never overflows.
- Response path:
  - mem_resp_o = mem_resp_i, combinational pass-through with no added latency.
  - mem_resp_v_o[head] = mem_resp_v_i & fifo_v. All other bits are 0.
  - mem_resp_ready_o = fifo_v & mem_resp_ready_i[head].
  - A response is accepted when mem_resp_v_i & mem_resp_ready_o; that cycle pops the FIFO.
  - Responses return in command order. Every command, read or write-back, produces exactly one response.
  - A response arriving while the FIFO is empty is not accepted (mem_resp_ready_o = 0). An assertion flags this as an error.
- Simultaneous push and pop:
  - Allowed, including when the FIFO is full: with the FIFO full, push is blocked in IDLE, but a pop in the same cycle frees a slot only for the next cycle.
  - outstanding_o is unchanged on a simultaneous push and pop; it increments on push only and decrements on pop only.
- num_req_p = 1: the pointer and grant are constant 0. The block degenerates to a pass-through with an outstanding limit.
- Reset mid-operation: HOLD, the pointer, the FIFO and the counter are all cleared. In-flight responses are discarded by the environment, which must be reset together with the arbiter.

Test Plan:
- num_req_p=2; both mem_cmd_v_i=1 continuously; mem_cmd_yumi_i=1 every cycle -> grants alternate 0,1,0,1; outstanding_o rises 1,2,3,4.
- Requester 0 valid, mem_cmd_yumi_i held 0 for 3 cycles, requester 1 raises valid in cycle 1 -> mem_cmd_o stays requester 0's message for 4 cycles; yumi_o[0] only in cycle 3; requester 1 granted next.
- Issue 8 commands with no responses (tag_fifo_els_p=8) -> mem_cmd_v_o=0 while a 9th is pending. One response pops -> the 9th issues the following cycle; outstanding_o stays 8.
- Issue order 1,0,1 -> three responses are steered to mem_resp_v_o = 2'b10, 2'b01, 2'b10 in order.
- Head requester has mem_resp_ready_i=0 for 2 cycles -> mem_resp_ready_o=0 and no pop; released on cycle 3.
- Reset asserted in HOLD with 3 outstanding -> next cycle: state IDLE, outstanding_o=0, all valid outputs 0.

Source files
------------

// File: rtl/bp_me_cce_mem_cmd_arbiter.sv
// Shares one CCE memory command/response channel pair among num_req_p
// requesters. Commands are granted round-robin. An in-order tag FIFO records
// which requester issued each command so that responses can be steered back.
module bp_me_cce_mem_cmd_arbiter #(
    parameter int num_req_p       = 2,
    parameter int mem_msg_width_p = 64,
    parameter int tag_fifo_els_p  = 8,
    localparam int lg_num_req_lp  = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int lg_els_lp      = $clog2(tag_fifo_els_p),
    localparam int cnt_w_lp       = $clog2(tag_fifo_els_p + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_req_p*mem_msg_width_p-1:0] mem_cmd_i,
    input  logic [num_req_p-1:0]                 mem_cmd_v_i,
    output logic [num_req_p-1:0]                 mem_cmd_yumi_o,
    output logic [mem_msg_width_p-1:0]           mem_cmd_o,
    output logic                                 mem_cmd_v_o,
    input  logic                                 mem_cmd_yumi_i,
    input  logic [mem_msg_width_p-1:0]           mem_resp_i,
    input  logic                                 mem_resp_v_i,
    output logic                                 mem_resp_ready_o,
    output logic [mem_msg_width_p-1:0]           mem_resp_o,
    output logic [num_req_p-1:0]                 mem_resp_v_o,
    input  logic [num_req_p-1:0]                 mem_resp_ready_i,
    output logic [cnt_w_lp-1:0]                  outstanding_o
);

    typedef enum logic {IDLE, HOLD} state_e;

    state_e                   state_q, state_d;
    logic [lg_num_req_lp-1:0] grant_q, grant_d;
    logic [lg_num_req_lp-1:0] rr_q, rr_d;
    logic [lg_num_req_lp-1:0] arb_grant, sel;
    logic                     arb_found;

    logic [lg_num_req_lp-1:0] tag_mem_q [tag_fifo_els_p];
    logic [lg_num_req_lp-1:0] tag_mem_d [tag_fifo_els_p];
    logic [lg_els_lp-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
    logic [cnt_w_lp-1:0]      count_q, count_d;
    logic [lg_num_req_lp-1:0] head;
    logic                     push, pop, fifo_v, fifo_full;

    // Requester index that follows g, wrapping at num_req_p.
    function automatic logic [lg_num_req_lp-1:0] next_ptr(input logic [lg_num_req_lp-1:0] g);
        if (int'(g) >= num_req_p - 1) return '0;
        else return g + 1'b1;
    endfunction

    assign fifo_v        = (count_q != '0);
    assign fifo_full     = (count_q == cnt_w_lp'(tag_fifo_els_p));
    assign head          = tag_mem_q[rptr_q];
    assign outstanding_o = count_q;
    assign mem_resp_o    = mem_resp_i;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        arb_grant = '0;
        arb_found = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            for (int j = 0; j < num_req_p; j++) begin
                if (!arb_found && (j == (int'(rr_q) + i) % num_req_p) && mem_cmd_v_i[j]) begin
                    arb_found = 1'b1;
                    arb_grant = lg_num_req_lp'(j);
                end
            end
        end
    end

    // Command FSM: grant in IDLE, freeze the grant in HOLD until consumed.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        sel         = grant_q;
        mem_cmd_v_o = 1'b0;
        push        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_found && !fifo_full) begin
                    sel         = arb_grant;
                    mem_cmd_v_o = 1'b1;
                    if (mem_cmd_yumi_i) begin
                        push = 1'b1;
                        rr_d = next_ptr(arb_grant);
                    end else begin
                        grant_d = arb_grant;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                mem_cmd_v_o = 1'b1;
                if (mem_cmd_yumi_i) begin
                    push    = 1'b1;
                    rr_d    = next_ptr(grant_q);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset_i) begin
            mem_cmd_v_o = 1'b0;
            push        = 1'b0;
        end
    end

    // Command data mux and one-hot consume back to the granted requester.
    always_comb begin
        mem_cmd_o      = '0;
        mem_cmd_yumi_o = '0;
        for (int j = 0; j < num_req_p; j++) begin
            if (lg_num_req_lp'(j) == sel) begin
                mem_cmd_o         = mem_cmd_i[j*mem_msg_width_p +: mem_msg_width_p];
                mem_cmd_yumi_o[j] = push;
            end
        end
    end

    // Response steering to the requester at the FIFO head.
    always_comb begin
        mem_resp_v_o     = '0;
        mem_resp_ready_o = 1'b0;
        for (int j = 0; j < num_req_p; j++) begin
            if (lg_num_req_lp'(j) == head) begin
                mem_resp_v_o[j]  = mem_resp_v_i & fifo_v & ~reset_i;
                mem_resp_ready_o = fifo_v & mem_resp_ready_i[j] & ~reset_i;
            end
        end
        pop = mem_resp_v_i & mem_resp_ready_o;
    end

    // Tag FIFO next state; occupancy moves only on push xor pop.
    always_comb begin
        tag_mem_d = tag_mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        if (push) begin
            tag_mem_d[wptr_q] = sel;
            wptr_d            = wptr_q + 1'b1;
        end
        if (pop) rptr_d = rptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Tag storage; validity is tracked by the pointers and count.
    always_ff @(posedge clk_i) begin
        tag_mem_q <= tag_mem_d;
    end

    // A response with nothing outstanding means the environment is broken.
    a_no_resp_when_empty: assert property (@(posedge clk_i) disable iff (reset_i)
        mem_resp_v_i |-> fifo_v);

endmodule

// File: tb/tb_bp_me_cce_mem_cmd_arbiter.sv
// Directed bench for bp_me_cce_mem_cmd_arbiter with two requesters,
// 16-bit messages and an 8-entry tag FIFO.
module tb_bp_me_cce_mem_cmd_arbiter;

    localparam int N = 2;
    localparam int W = 16;
    localparam int E = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [N*W-1:0] mem_cmd_i;
    logic [N-1:0]  mem_cmd_v_i;
    logic [N-1:0]  mem_cmd_yumi_o;
    logic [W-1:0]  mem_cmd_o;
    logic          mem_cmd_v_o;
    logic          mem_cmd_yumi_i;
    logic [W-1:0]  mem_resp_i;
    logic          mem_resp_v_i;
    logic          mem_resp_ready_o;
    logic [W-1:0]  mem_resp_o;
    logic [N-1:0]  mem_resp_v_o;
    logic [N-1:0]  mem_resp_ready_i;
    logic [3:0]    outstanding_o;

    int n_checks = 0;
    int n_fail   = 0;

    bp_me_cce_mem_cmd_arbiter #(
        .num_req_p(N), .mem_msg_width_p(W), .tag_fifo_els_p(E)
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .mem_cmd_i(mem_cmd_i), .mem_cmd_v_i(mem_cmd_v_i), .mem_cmd_yumi_o(mem_cmd_yumi_o),
        .mem_cmd_o(mem_cmd_o), .mem_cmd_v_o(mem_cmd_v_o), .mem_cmd_yumi_i(mem_cmd_yumi_i),
        .mem_resp_i(mem_resp_i), .mem_resp_v_i(mem_resp_v_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_o(mem_resp_o), .mem_resp_v_o(mem_resp_v_o), .mem_resp_ready_i(mem_resp_ready_i),
        .outstanding_o(outstanding_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_i          = 1'b1;
        mem_cmd_i        = {16'hC001, 16'hC000};
        mem_cmd_v_i      = 2'b11;
        mem_cmd_yumi_i   = 1'b0;
        mem_resp_i       = '0;
        mem_resp_v_i     = 1'b0;
        mem_resp_ready_i = 2'b11;

        // Reset state
        tick();
        #1;
        check("rst_cmd_v", 32'(mem_cmd_v_o), 0);
        mem_cmd_v_i = 2'b00;
        tick();
        reset_i = 1'b0;
        #1;
        check("rst_outstanding", 32'(outstanding_o), 0);
        check("rst_cmd_v_idle", 32'(mem_cmd_v_o), 0);
        check("rst_yumi", 32'(mem_cmd_yumi_o), 0);
        check("rst_resp_v", 32'(mem_resp_v_o), 0);
        check("rst_resp_ready", 32'(mem_resp_ready_o), 0);

        // Both requesting, downstream always consuming: grants alternate
        mem_cmd_v_i    = 2'b11;
        mem_cmd_yumi_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("alt_cmd_v", 32'(mem_cmd_v_o), 1);
            check("alt_cmd_o", 32'(mem_cmd_o), (k % 2 == 0) ? 32'hC000 : 32'hC001);
            check("alt_yumi", 32'(mem_cmd_yumi_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            tick();
            check("alt_outstanding", 32'(outstanding_o), 32'(k + 1));
        end
        mem_cmd_v_i    = 2'b00;
        mem_cmd_yumi_i = 1'b0;
        mem_resp_v_i   = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mem_resp_i = 16'hD000 + 16'(k);
            #1;
            check("alt_resp_v", 32'(mem_resp_v_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            check("alt_resp_o", 32'(mem_resp_o), 32'hD000 + 32'(k));
            check("alt_resp_ready", 32'(mem_resp_ready_o), 1);
            tick();
            check("alt_drain", 32'(outstanding_o), 32'(3 - k));
        end
        mem_resp_v_i = 1'b0;

        // HOLD keeps requester 0's command stable while downstream stalls
        mem_cmd_i   = {16'hBBBB, 16'hAAAA};
        mem_cmd_v_i = 2'b01;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) mem_cmd_v_i = 2'b11;
            if (c == 3) mem_cmd_yumi_i = 1'b1;
            #1;
            check("hold_cmd_v", 32'(mem_cmd_v_o), 1);
            check("hold_cmd_o", 32'(mem_cmd_o), 32'hAAAA);
            check("hold_yumi", 32'(mem_cmd_yumi_o), (c == 3) ? 32'h1 : 32'h0);
            tick();
        end
        mem_cmd_v_i = 2'b10;
        #1;
        check("hold_next_cmd_o", 32'(mem_cmd_o), 32'hBBBB);
        check("hold_next_yumi", 32'(mem_cmd_yumi_o), 32'h2);
        tick();
        mem_cmd_v_i    = 2'b00;
        mem_cmd_yumi_i = 1'b0;
        check("hold_outstanding", 32'(outstanding_o), 2);

        // Head requester not ready: no pop until it is
        mem_resp_v_i     = 1'b1;
        mem_resp_i       = 16'hE000;
        mem_resp_ready_i = 2'b10;
        for (int c = 0; c < 2; c++) begin
            #1;
            check("bp_ready_o", 32'(mem_resp_ready_o), 0);
            check("bp_resp_v", 32'(mem_resp_v_o), 32'h1);
            tick();
            check("bp_no_pop", 32'(outstanding_o), 2);
        end
        mem_resp_ready_i = 2'b11;
        #1;
        check("bp_release", 32'(mem_resp_ready_o), 1);
        tick();
        check("bp_pop", 32'(outstanding_o), 1);
        mem_resp_i = 16'hE001;
        #1;
        check("bp_second_v", 32'(mem_resp_v_o), 32'h2);
        tick();
        mem_resp_v_i = 1'b0;
        check("bp_empty", 32'(outstanding_o), 0);

        // Issue order 1,0,1 then check response steering
        mem_cmd_yumi_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mem_cmd_v_i = (k == 1) ? 2'b01 : 2'b10;
            #1;
            check("ord_yumi", 32'(mem_cmd_yumi_o), (k == 1) ? 32'h1 : 32'h2);
            tick();
        end
        mem_cmd_v_i    = 2'b00;
        mem_cmd_yumi_i = 1'b0;
        mem_resp_v_i   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ord_resp_v", 32'(mem_resp_v_o), (k == 1) ? 32'h1 : 32'h2);
            tick();
        end
        mem_resp_v_i = 1'b0;
        check("ord_empty", 32'(outstanding_o), 0);

        // Fill the tag FIFO; the ninth command must wait for a pop
        mem_cmd_i      = {16'h9001, 16'h9000};
        mem_cmd_v_i    = 2'b01;
        mem_cmd_yumi_i = 1'b1;
        for (int k = 0; k < E; k++) tick();
        mem_cmd_yumi_i = 1'b0;
        check("full_outstanding", 32'(outstanding_o), 8);
        #1;
        check("full_cmd_v", 32'(mem_cmd_v_o), 0);
        tick();
        check("full_cmd_v_hold", 32'(mem_cmd_v_o), 0);
        check("full_still8", 32'(outstanding_o), 8);
        mem_resp_v_i = 1'b1;
        #1;
        check("full_pop_ready", 32'(mem_resp_ready_o), 1);
        check("full_pop_cmd_v", 32'(mem_cmd_v_o), 0);
        tick();
        mem_resp_v_i   = 1'b0;
        mem_cmd_yumi_i = 1'b1;
        #1;
        check("ninth_cmd_v", 32'(mem_cmd_v_o), 1);
        check("ninth_yumi", 32'(mem_cmd_yumi_o), 32'h1);
        tick();
        mem_cmd_yumi_i = 1'b0;
        check("ninth_outstanding", 32'(outstanding_o), 8);
        mem_resp_v_i = 1'b1;
        tick();
        check("pop_to7", 32'(outstanding_o), 7);
        mem_cmd_yumi_i = 1'b1;
        #1;
        check("pushpop_yumi", 32'(mem_cmd_yumi_o), 32'h1);
        check("pushpop_ready", 32'(mem_resp_ready_o), 1);
        tick();
        mem_cmd_yumi_i = 1'b0;
        mem_cmd_v_i    = 2'b00;
        check("pushpop_same", 32'(outstanding_o), 7);
        for (int k = 0; k < 7; k++) begin
            #1;
            check("full_drain_v", 32'(mem_resp_v_o), 32'h1);
            tick();
        end
        mem_resp_v_i = 1'b0;
        check("full_drained", 32'(outstanding_o), 0);

        // Reset while in HOLD with three outstanding
        mem_cmd_v_i    = 2'b01;
        mem_cmd_yumi_i = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        mem_cmd_yumi_i = 1'b0;
        tick();
        #1;
        check("pre_rst_hold_v", 32'(mem_cmd_v_o), 1);
        check("pre_rst_outstanding", 32'(outstanding_o), 3);
        reset_i     = 1'b1;
        mem_cmd_v_i = 2'b00;
        tick();
        reset_i = 1'b0;
        #1;
        check("mid_rst_outstanding", 32'(outstanding_o), 0);
        check("mid_rst_cmd_v", 32'(mem_cmd_v_o), 0);
        check("mid_rst_resp_v", 32'(mem_resp_v_o), 0);
        check("mid_rst_ready", 32'(mem_resp_ready_o), 0);
        check("mid_rst_yumi", 32'(mem_cmd_yumi_o), 0);
        mem_cmd_i   = {16'hBEEF, 16'h9000};
        mem_cmd_v_i = 2'b10;
        #1;
        check("mid_rst_idle_cmd_o", 32'(mem_cmd_o), 32'hBEEF);
        tick();
        mem_cmd_v_i = 2'b00;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
